alu_seq: RTL and testbench

Parametrised, clocked successor to the 7-bit combinational ALU. It accepts operands through a valid/ready handshake and executes ADD, SUB and AND in one cycle. MUL is executed iteratively by shift-add over WIDTH cycles. Result and flags (CF, GZ, ZF) are registered and held until the consumer accepts them. It sits between the control FSM and the result register file in the sky130 datapath.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 123 ++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the control FSM (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             CF;
  logic             GZ;
  logic             ZF;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, CF, GZ, ZF, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, CF, GZ, ZF, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND, shift-add MUL over WIDTH cycles,
// registered result and flags held until the consumer accepts them.
module alu_seq #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 5
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   res_q;
  logic               cf_q;
  logic               gz_q;
  logic               zf_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   new_res;
  logic               new_cf;
  logic               accept;
  logic               mul_last;
  logic               load;

  // One result path feeds the output registers: the single-cycle ops from the
  // live operands at accept, or the finished accumulator on the last MUL step.
  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = {1'b0, bus.a} - {1'b0, bus.b};
    acc_step = mplier[0] ? (acc + mcand) : acc;
    accept   = (state == S_IDLE) && bus.in_valid;
    mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));
    new_res  = bus.a & bus.b;
    new_cf   = 1'b0;
    if (state == S_MUL) begin
      new_res = acc_step[WIDTH-1:0];
      new_cf  = |acc_step[2*WIDTH-1:WIDTH];
    end else begin
      case (bus.op)
        OP_ADD: begin
          new_res = sum[WIDTH-1:0];
          new_cf  = sum[WIDTH];
        end
        OP_SUB: begin
          new_res = diff[WIDTH-1:0];
          new_cf  = diff[WIDTH];
        end
        default: ;
      endcase
    end
    load = (accept && (bus.op != OP_MUL)) || mul_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      res_q  <= '0;
      cf_q   <= 1'b0;
      gz_q   <= 1'b0;
      zf_q   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      if (load) begin
        res_q <= new_res;
        cf_q  <= new_cf;
        zf_q  <= ~|new_res;
        gz_q  <= ~new_res[WIDTH-1] & (|new_res);
      end
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              acc    <= '0;
              cnt    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              state  <= S_MUL;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // Multiplier consumed LSB first; multiplicand shifts up to match.
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_MUL);
  assign bus.res       = res_q;
  assign bus.CF        = cf_q;
  assign bus.GZ        = gz_q;
  assign bus.ZF        = zf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases at WIDTH=7, then random
// regression at WIDTH=7 and WIDTH=16 against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(7))  if7 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  logic        sel         = 1'b0;
  logic        drvValid    = 1'b0;
  logic        drvOutReady = 1'b0;
  logic [31:0] drvA        = '0;
  logic [31:0] drvB        = '0;
  logic [1:0]  drvOp       = '0;

  assign if7.in_valid   = drvValid & ~sel;
  assign if7.out_ready  = drvOutReady & ~sel;
  assign if7.a          = drvA[6:0];
  assign if7.b          = drvB[6:0];
  assign if7.op         = drvOp;
  assign if16.in_valid  = drvValid & sel;
  assign if16.out_ready = drvOutReady & sel;
  assign if16.a         = drvA[15:0];
  assign if16.b         = drvB[15:0];
  assign if16.op        = drvOp;

  logic        obsInReady;
  logic        obsOutValid;
  logic        obsBusy;
  logic        obsCF;
  logic        obsGZ;
  logic        obsZF;
  logic [31:0] obsRes;

  assign obsInReady  = sel ? if16.in_ready  : if7.in_ready;
  assign obsOutValid = sel ? if16.out_valid : if7.out_valid;
  assign obsBusy     = sel ? if16.busy      : if7.busy;
  assign obsCF       = sel ? if16.CF        : if7.CF;
  assign obsGZ       = sel ? if16.GZ        : if7.GZ;
  assign obsZF       = sel ? if16.ZF        : if7.ZF;
  assign obsRes      = sel ? {16'd0, if16.res} : {25'd0, if7.res};

  alu_seq #(.WIDTH(7), .CNT_W(5)) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (if7.slave)
  );

  alu_seq #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input longint unsigned observed,
                             input longint unsigned expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour straight from the arithmetic definitions.
  function automatic void modelOp(input int w, input logic [1:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned res, output bit cf,
                                  output bit gz, output bit zf);
    longint unsigned mask;
    longint unsigned full;
    mask = (64'd1 << w) - 1;
    case (op)
      2'd0: begin full = a + b; res = full & mask; cf = (full >> w) != 0; end
      2'd1: begin res = (a - b) & mask; cf = (a < b); end
      2'd2: begin full = a * b; res = full & mask; cf = (full >> w) != 0; end
      default: begin res = a & b; cf = 1'b0; end
    endcase
    zf = (res == 0);
    gz = (res != 0) && (((res >> (w - 1)) & 1) == 0);
  endfunction

  function automatic longint unsigned randOperand(input int w);
    int unsigned pick;
    longint unsigned mask;
    mask = (64'd1 << w) - 1;
    pick = $urandom_range(0, 9);
    if (pick == 0) return 0;
    if (pick == 1) return mask;
    return longint'($urandom) & mask;
  endfunction

  // Issues one op at the current negedge (DUT must be idle), garbles the
  // inputs while it runs, holds the consumer off for 'hold' cycles, then
  // completes the handshake and leaves the bench at a negedge with DUT idle.
  task automatic applyStimulus(input logic [1:0] op, input longint unsigned a,
                               input longint unsigned b, input int hold);
    int w;
    int lat;
    int busyCnt;
    longint unsigned expRes;
    bit expCF;
    bit expGZ;
    bit expZF;
    w = sel ? 16 : 7;
    modelOp(w, op, a, b, expRes, expCF, expGZ, expZF);
    checkOutput("in_ready_before_issue", obsInReady, 1);
    drvValid    = 1'b1;
    drvA        = 32'(a);
    drvB        = 32'(b);
    drvOp       = op;
    drvOutReady = 1'b0;
    lat         = 0;
    busyCnt     = 0;
    do begin
      @(negedge clk);
      lat++;
      if (obsBusy) busyCnt++;
      drvValid = 1'($urandom_range(0, 1));
      drvA     = $urandom;
      drvB     = $urandom;
      drvOp    = 2'($urandom_range(0, 3));
    end while (!obsOutValid && lat < 64);
    checkOutput("latency", lat, (op == 2'd2) ? w + 1 : 1);
    checkOutput("busy_cycles", busyCnt, (op == 2'd2) ? w : 0);
    checkOutput("res", obsRes, expRes);
    checkOutput("CF", obsCF, expCF);
    checkOutput("GZ", obsGZ, expGZ);
    checkOutput("ZF", obsZF, expZF);
    checkOutput("in_ready_in_done", obsInReady, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", obsOutValid, 1);
      checkOutput("hold_res", obsRes, expRes);
      checkOutput("hold_in_ready", obsInReady, 0);
      drvValid = 1'b1;
      drvA     = $urandom;
      drvB     = $urandom;
      drvOp    = 2'($urandom_range(0, 3));
    end
    drvValid    = 1'b0;
    drvOutReady = 1'b1;
    @(negedge clk);
    drvOutReady = 1'b0;
    checkOutput("post_out_valid", obsOutValid, 0);
    checkOutput("post_in_ready", obsInReady, 1);
    checkOutput("post_res_kept", obsRes, expRes);
    checkOutput("post_CF_kept", obsCF, expCF);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, obsInReady, 1);
    checkOutput({tag, "_out_valid"}, obsOutValid, 0);
    checkOutput({tag, "_busy"}, obsBusy, 0);
    checkOutput({tag, "_res"}, obsRes, 0);
    checkOutput({tag, "_CF"}, obsCF, 0);
    checkOutput({tag, "_GZ"}, obsGZ, 0);
    checkOutput({tag, "_ZF"}, obsZF, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    applyStimulus(2'd0, 100, 50, 0);
    applyStimulus(2'd1, 5, 9, 1);
    applyStimulus(2'd1, 9, 9, 0);
    applyStimulus(2'd2, 12, 11, 0);
    applyStimulus(2'd2, 127, 127, 2);
    applyStimulus(2'd2, 0, 127, 0);
    applyStimulus(2'd2, 127, 0, 0);
    applyStimulus(2'd3, 64'h55, 64'h3C, 5);

    // Reset in the third MUL cycle must discard the op entirely.
    drvValid = 1'b1;
    drvA     = 32'd12;
    drvB     = 32'd11;
    drvOp    = 2'd2;
    @(negedge clk);
    drvValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mul_busy_before_reset", obsBusy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("mid_mul_reset");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obsOutValid) pulses++;
    end
    checkOutput("no_out_valid_after_reset", pulses, 0);
    applyStimulus(2'd0, 1, 1, 0);

    for (int i = 0; i < 1000; i++)
      applyStimulus(2'($urandom_range(0, 3)), randOperand(7), randOperand(7),
                    $urandom_range(0, 3));

    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++)
      applyStimulus(2'($urandom_range(0, 3)), randOperand(16), randOperand(16),
                    $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
